// File: rtl/hebbian_pkg.sv
// Shared types and constants for the Hebbian sweep scheduler.
// Defaults: N=7 neurons, W=8 bit signed weights, IDX_W=3 index bits.
package hebbian_pkg;

  localparam int N_DEF     = 7;
  localparam int W_DEF     = 8;
  localparam int IDX_W_DEF = 3;

  function automatic int w_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  function automatic int w_min(input int w);
    return -(2 ** (w - 1));
  endfunction

  localparam int W_MAX = w_max(W_DEF);
  localparam int W_MIN = w_min(W_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/hebbian_sweep_scheduler_arbiter.sv
// Grants the shared weight port to host reads, alternating with the sweep in SCAN.
// One flag records the previous grant: it drives both the fairness rule and host_rvalid.
module hebbian_port_arbiter
  import hebbian_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_host_req,
  input  logic         i_arb_open,
  input  logic         i_in_scan,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_host_gnt,
  output logic         o_host_rvalid,
  output logic [W-1:0] o_host_rdata
);

  logic r_host_last;

  // reset_n gates the grant so the port stays quiet while reset is held
  assign o_host_gnt    = reset_n && i_host_req && i_arb_open && !(i_in_scan && r_host_last);
  assign o_host_rvalid = r_host_last;
  assign o_host_rdata  = r_host_last ? i_mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_host_last <= 1'b0;
    end else begin
      r_host_last <= o_host_gnt;
    end
  end

endmodule

// File: rtl/hebbian_sweep_scheduler.sv
// Hebbian sweep engine: one saturating RMW pass over the NxN weights per snapshot.
// Optional decay of half-active pairs is enabled with the HEBB_DECAY_EN macro.
//
// Handshake: a snapshot transfers on a rising clk edge where spike_valid && spike_ready;
// spike_ready never depends on spike_valid, and spikes is sampled only on that edge.
module hebbian_sweep_scheduler
  import hebbian_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             learn_en,
  input  logic             spike_valid,
  output logic             spike_ready,
  input  logic [N-1:0]     spikes,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_i,
  output logic [IDX_W-1:0] mem_j,
  output logic [W-1:0]     mem_wdata,
  input  logic [W-1:0]     mem_rdata,
  input  logic             host_req,
  input  logic [IDX_W-1:0] host_i,
  input  logic [IDX_W-1:0] host_j,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [W-1:0]     host_rdata,
  output logic             busy,
  output logic             sweep_done,
  output logic [15:0]      update_count,
  output logic [W-1:0]     last_weight,
  output logic [1:0]       dbg_state
);

  localparam logic [W-1:0]     C_MAX  = W'(w_max(W));
  localparam logic [W-1:0]     C_MIN  = W'(w_min(W));
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N - 1);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_snap;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic [15:0]      r_count;
  logic [W-1:0]     r_last;
  logic             r_done;

  logic         w_host_gnt;
  logic         w_si;
  logic         w_sj;
  logic         w_pair_pos;
  logic         w_pair_neg;
  logic         w_elig;
  logic         w_last_pair;
  logic         w_do_write;
  logic [W-1:0] w_wdata;
  logic         w_adv;
  logic         w_accept;
  logic         w_write;

  hebbian_port_arbiter #(.W(W)) u_arb (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_host_req    (host_req),
    .i_arb_open    ((r_state == IDLE) || (r_state == SCAN)),
    .i_in_scan     (r_state == SCAN),
    .i_mem_rdata   (mem_rdata),
    .o_host_gnt    (w_host_gnt),
    .o_host_rvalid (host_rvalid),
    .o_host_rdata  (host_rdata)
  );

  assign w_si        = r_snap[r_i];
  assign w_sj        = r_snap[r_j];
  assign w_pair_pos  = w_si && w_sj && (r_i != r_j);
`ifdef HEBB_DECAY_EN
  assign w_pair_neg  = (w_si ^ w_sj) && (r_i != r_j);
`else
  assign w_pair_neg  = 1'b0;
`endif
  assign w_elig      = w_pair_pos || w_pair_neg;
  assign w_last_pair = (r_i == C_LAST) && (r_j == C_LAST);

  // Snapshot and indices are stable through WRITE, so the pair class is recomputed there.
  assign w_do_write = w_pair_pos ? (mem_rdata != C_MAX) : (mem_rdata != C_MIN);
  assign w_wdata    = w_pair_pos ? (mem_rdata + W'(1)) : (mem_rdata - W'(1));

  always_comb begin
    w_next      = r_state;
    spike_ready = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_i       = '0;
    mem_j       = '0;
    mem_wdata   = '0;
    w_adv       = 1'b0;
    w_accept    = 1'b0;
    w_write     = 1'b0;
    if (w_host_gnt) begin
      mem_en = 1'b1;
      mem_i  = host_i;
      mem_j  = host_j;
    end
    case (r_state)
      IDLE: begin
        // r_done holds off acceptance in the cycle sweep_done is shown
        spike_ready = reset_n && learn_en && !w_host_gnt && !r_done;
        if (spike_valid && spike_ready) begin
          w_accept = 1'b1;
          w_next   = SCAN;
        end
      end
      SCAN: begin
        if (!learn_en) begin
          w_next = IDLE;
        end else if (!w_host_gnt) begin
          if (w_elig) begin
            mem_en = 1'b1;
            mem_i  = r_i;
            mem_j  = r_j;
            w_next = WRITE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      WRITE: begin
        if (w_do_write) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_i     = r_i;
          mem_j     = r_j;
          mem_wdata = w_wdata;
          w_write   = 1'b1;
        end
        if (!learn_en) begin
          w_next = IDLE;
        end else begin
          w_adv  = 1'b1;
          w_next = SCAN;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_adv && w_last_pair) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_adv && w_last_pair;
      if (w_accept) begin
        r_snap <= spikes;
        r_i    <= '0;
        r_j    <= '0;
      end else if (w_adv) begin
        if (r_j == C_LAST) begin
          r_j <= '0;
          r_i <= r_i + IDX_W'(1);
        end else begin
          r_j <= r_j + IDX_W'(1);
        end
      end
      if (w_write) begin
        r_last <= w_wdata;
        if (r_count != 16'hFFFF) begin
          r_count <= r_count + 16'd1;
        end
      end
    end
  end

  assign host_gnt     = w_host_gnt;
  assign busy         = (r_state != IDLE);
  assign sweep_done   = r_done;
  assign update_count = r_count;
  assign last_weight  = r_last;
  assign dbg_state    = r_state;

endmodule

// File: doc/hebbian_sweep_scheduler.md
Name: hebbian_sweep_scheduler

Overview:
Sequences Hebbian learning over an N×N signed weight memory, one update sweep per accepted spike snapshot.
- Walks all (i,j) pairs and issues a read-modify-write (saturating +1) for each co-active pair with i≠j.
- Shares the single weight-memory port with a host read requester.
- Sits between the neuron array's spike output and the weight storage; replaces a free-running pair counter with a handshaked, arbitrated sweep engine.

Parameters:
- N, 7, number of neurons; weight matrix is N×N.
- W, 8, signed weight width in bits.
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ N.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- learn_en  in  1  enables snapshot acceptance; deassertion aborts the sweep.
- spike_valid  in  1  spike snapshot offered.
- spike_ready  out  1  scheduler can accept a snapshot.
- spikes  in  N  spike vector; sampled on the handshake edge.
- mem_en  out  1  weight-port access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_i  out  IDX_W  row index (presynaptic).
- mem_j  out  IDX_W  column index (postsynaptic).
- mem_wdata  out  W  write data.
- mem_rdata  in  W  read data, valid exactly one cycle after a read strobe.
- host_req  in  1  host read request; level, held until granted.
- host_i  in  IDX_W  host row index.
- host_j  in  IDX_W  host column index.
- host_gnt  out  1  host read issued this cycle.
- host_rvalid  out  1  host_rdata valid; one cycle after host_gnt.
- host_rdata  out  W  weight returned to host.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when a sweep completes normally.
- update_count  out  16  number of weight writes; saturates at 0xFFFF.
- last_weight  out  W  value of the most recent weight write.

Behaviour:
- Reset: every output is 0, FSM in IDLE, snapshot register and indices cleared.
- FSM states:
  - IDLE: spike_ready = learn_en && !host_gnt. On spike_valid && spike_ready, latch spikes, set i=j=0, go to SCAN.
  - SCAN: evaluate pair (i,j).
    - Eligible if snap[i] && snap[j] && i≠j. Drive a read (mem_en=1, mem_we=0, mem_i=i, mem_j=j) and go to WRITE.
    - Not eligible: advance the pair, 1 cycle per pair.
  - WRITE: mem_rdata holds weight[i][j].
    - If rdata < 2^(W-1)-1: write rdata+1, set last_weight, increment update_count.
    - Else (saturated): no write, counters unchanged.
    - Then advance the pair.
- Advance order: j increments first; at j=N-1, set j=0 and i++. Advancing past (N-1,N-1) returns to IDLE with sweep_done=1 for one cycle. A new snapshot can be accepted no earlier than the cycle after sweep_done.
- busy = 1 in SCAN and WRITE.
- Arbitration (IDLE or SCAN only; never between a read and its WRITE):
  - host_req wins, except in the cycle immediately after a host grant while in SCAN, where the sweep wins. This is alternating fairness and guarantees sweep progress.
  - On a grant: host_gnt=1, mem_en=1, mem_we=0, address = host_i/host_j.
  - Next cycle: host_rvalid=1, host_rdata=mem_rdata.
  - A SCAN cycle lost to the host does not advance the pair.
- learn_en falling during SCAN: return to IDLE next cycle, no sweep_done.
- learn_en falling during WRITE: the write completes, then return to IDLE, no sweep_done.
- A snapshot is never accepted while busy; spikes changing mid-sweep has no effect.
- Arithmetic: signed compare and add at width W. No wrap-around ever.

Optional Feature:
Macro HEBB_DECAY_EN.
- Defined: pairs with exactly one of snap[i], snap[j] set and i≠j are also RMW'd, writing rdata-1, floored at -2^(W-1) (no write at the floor). These writes count in update_count and last_weight.
- Undefined: those pairs are skipped as ineligible.

Decomposition:
- Package hebbian_pkg holds:
  - FSM state enum {IDLE, SCAN, WRITE};
  - W_MAX and W_MIN constants derived from W;
  - the N/IDX_W defaults.
- One sub-module, hebbian_port_arbiter: the host/sweep grant logic with the fairness flag, and host_rvalid generation.

Test Plan:
1. N=7, memory zeroed, spikes=7'b0000011 accepted → writes only (0,1)=1 and (1,0)=1; SCAN+WRITE occupy exactly 51 cycles; sweep_done pulses once; update_count=2.
2. Weight (2,3) preloaded 127, spikes=7'b0001100 → no write to (2,3); (3,2) goes 0→1; update_count=1; last_weight=1.
3. host_req held high throughout a sweep with spikes=7'h7F → host grants alternate with sweep cycles; each host_rvalid is exactly one cycle after host_gnt; the sweep completes with 42 writes.
4. learn_en dropped while in WRITE at pair (0,1) → that write lands; FSM goes to IDLE; no sweep_done; busy=0 next cycle.
5. reset_n asserted mid-sweep → all outputs 0 immediately, asynchronously; next snapshot starts at (0,0).
6. HEBB_DECAY_EN defined, (0,2) preloaded -128, spikes=7'b0000011 → (0,2) unchanged; (0,3) goes 0→-1.
